// File: rtl/hub75_capture.sv
// HUB75 panel-side receiver: rebuilds each shifted line and writes it into a capture RAM at {row, column}.
// Define HUB75_CAP_OE_STATS_EN to build the output-enable lit-time counter (oe_on_cycles / oe_stat_valid).
module hub75_capture #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_p_clk,
  input  logic                              i_p_lat,
  input  logic                              i_p_oe,
  input  logic [ROW_BITS-1:0]               i_p_addr,
  input  logic [2:0]                        i_p_rgb1,
  input  logic [2:0]                        i_p_rgb2,
  output logic                              o_wr_en,
  output logic [ROW_BITS+$clog2(COLS)-1:0]  o_wr_addr,
  output logic [5:0]                        o_wr_data,
  output logic                              o_row_done,
  output logic                              o_frame_done,
  output logic                              o_overrun,
  output logic                              o_lat_drop,
  output logic [15:0]                       o_oe_on_cycles,
  output logic                              o_oe_stat_valid
);

  localparam int COL_BITS = $clog2(COLS);
  localparam int AW       = ROW_BITS + COL_BITS;
  localparam int SW       = ROW_BITS + 8;
  localparam logic [SW-1:0]       SYNC_RST = {1'b1, {(SW-1){1'b0}}};
  localparam logic [COL_BITS-1:0] COL_MAX  = COL_BITS'(COLS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  logic [SW-1:0]       r_sync1;
  logic [SW-1:0]       r_sync2;
  logic                r_clk_d;
  logic                r_lat_d;
  logic                w_clk_s;
  logic                w_lat_s;
  logic [ROW_BITS-1:0] w_addr_s;
  logic [5:0]          w_pix;
  logic                w_clk_rise;
  logic                w_lat_fall;
  logic                w_accept;

  logic [5:0]          r_shift [COLS];
  logic [5:0]          r_hold  [COLS];
  logic [COL_BITS-1:0] r_col;
  logic [COL_BITS-1:0] w_col_base;
  logic                r_full;
  logic                w_full_base;
  logic [ROW_BITS-1:0] r_row;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [COL_BITS-1:0] r_c;
  logic [COL_BITS-1:0] w_c_nxt;
  logic                r_wr_en;
  logic                w_wr_en_nxt;
  logic [AW-1:0]       r_wr_addr;
  logic [AW-1:0]       w_wr_addr_nxt;
  logic [5:0]          r_wr_data;
  logic [5:0]          w_wr_data_nxt;
  logic                r_row_done;
  logic                w_row_done_nxt;
  logic                r_frame_done;
  logic                w_frame_done_nxt;
  logic                r_overrun;
  logic                r_lat_drop;

  // Two sync flops on every panel input; p_clk resets high so no false rising edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= SYNC_RST;
      r_sync2 <= SYNC_RST;
      r_clk_d <= 1'b1;
      r_lat_d <= 1'b0;
    end else begin
      r_sync1 <= {i_p_clk, i_p_lat, i_p_addr, i_p_rgb2, i_p_rgb1};
      r_sync2 <= r_sync1;
      r_clk_d <= w_clk_s;
      r_lat_d <= w_lat_s;
    end
  end

  assign w_clk_s    = r_sync2[SW-1];
  assign w_lat_s    = r_sync2[SW-2];
  assign w_addr_s   = r_sync2[6 +: ROW_BITS];
  assign w_pix      = r_sync2[5:0];
  assign w_clk_rise = w_clk_s & ~r_clk_d;
  assign w_lat_fall = ~w_lat_s & r_lat_d;
  // r_wr_en still high means the last column is on the bus; the line is not finished yet.
  assign w_accept   = w_lat_fall & (r_state == ST_IDLE) & ~r_wr_en;

  // A pixel arriving with the latch belongs to the new line, so the column base restarts first.
  assign w_col_base  = w_lat_fall ? {COL_BITS{1'b0}} : r_col;
  assign w_full_base = w_lat_fall ? 1'b0 : r_full;

  // Column counter, full-line tracking and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= {COL_BITS{1'b0}};
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_clk_rise) begin
      r_col     <= w_col_base + COL_BITS'(1);
      r_full    <= w_full_base | (w_col_base == COL_MAX);
      r_overrun <= r_overrun | w_full_base;
    end else if (w_lat_fall) begin
      r_col  <= {COL_BITS{1'b0}};
      r_full <= 1'b0;
    end
  end

  // Pixel buffers keep their contents across reset and short lines.
  always_ff @(posedge clk) begin
    if (w_clk_rise) begin
      r_shift[w_col_base] <= w_pix;
    end
    if (w_accept) begin
      r_hold <= r_shift;
    end
  end

  // Row capture and sticky latch-drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row      <= {ROW_BITS{1'b0}};
      r_lat_drop <= 1'b0;
    end else begin
      if (w_accept) begin
        r_row <= w_addr_s;
      end
      if (w_lat_fall && !w_accept) begin
        r_lat_drop <= 1'b1;
      end
    end
  end

  // Write FSM state and registered RAM-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_c          <= {COL_BITS{1'b0}};
      r_wr_en      <= 1'b0;
      r_wr_addr    <= {AW{1'b0}};
      r_wr_data    <= 6'd0;
      r_row_done   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_c          <= w_c_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_row_done   <= w_row_done_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Outputs are computed one cycle ahead; column 0 comes straight from the shift buffer being copied.
  always_comb begin
    w_state_nxt      = r_state;
    w_c_nxt          = r_c;
    w_wr_en_nxt      = 1'b0;
    w_wr_addr_nxt    = {AW{1'b0}};
    w_wr_data_nxt    = 6'd0;
    w_row_done_nxt   = 1'b0;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt   = ST_WRITE;
          w_c_nxt       = COL_BITS'(1);
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = {w_addr_s, {COL_BITS{1'b0}}};
          w_wr_data_nxt = r_shift[0];
        end else begin
          w_c_nxt = {COL_BITS{1'b0}};
        end
      end
      ST_WRITE: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = {r_row, r_c};
        w_wr_data_nxt = r_hold[r_c];
        if (r_c == COL_MAX) begin
          w_state_nxt      = ST_IDLE;
          w_c_nxt          = {COL_BITS{1'b0}};
          w_row_done_nxt   = 1'b1;
          w_frame_done_nxt = &r_row;
        end else begin
          w_c_nxt = r_c + COL_BITS'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_c_nxt     = {COL_BITS{1'b0}};
      end
    endcase
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_row_done   = r_row_done;
  assign o_frame_done = r_frame_done;
  assign o_overrun    = r_overrun;
  assign o_lat_drop   = r_lat_drop;

`ifdef HUB75_CAP_OE_STATS_EN
  logic        r_oe_s1;
  logic        r_oe_s2;
  logic [15:0] r_oe_cnt;
  logic [15:0] r_oe_on;
  logic        r_oe_valid;

  // Lit-time counter: counts synced p_oe low cycles, reported and restarted on every latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_oe_s1    <= 1'b0;
      r_oe_s2    <= 1'b0;
      r_oe_cnt   <= 16'd0;
      r_oe_on    <= 16'd0;
      r_oe_valid <= 1'b0;
    end else begin
      r_oe_s1    <= i_p_oe;
      r_oe_s2    <= r_oe_s1;
      r_oe_valid <= w_lat_fall;
      if (w_lat_fall) begin
        r_oe_on  <= r_oe_cnt;
        r_oe_cnt <= 16'd0;
      end else if (!r_oe_s2 && (r_oe_cnt != 16'hFFFF)) begin
        r_oe_cnt <= r_oe_cnt + 16'd1;
      end
    end
  end

  assign o_oe_on_cycles  = r_oe_on;
  assign o_oe_stat_valid = r_oe_valid;
`else
  logic w_unused_oe;

  assign w_unused_oe     = i_p_oe;
  assign o_oe_on_cycles  = 16'd0;
  assign o_oe_stat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Directed self-checking bench for hub75_capture: drives HUB75 lines and checks the captured RAM writes.
module tb_hub75_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p_clk = 1'b1;
  logic       p_lat = 1'b0;
  logic       p_oe = 1'b1;
  logic [3:0] p_addr = 4'd0;
  logic [2:0] p_rgb1 = 3'd0;
  logic [2:0] p_rgb2 = 3'd0;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [5:0]  wr_data;
  logic        row_done;
  logic        frame_done;
  logic        overrun;
  logic        lat_drop;
  logic [15:0] oe_on_cycles;
  logic        oe_stat_valid;

  int checks = 0;
  int errors = 0;

  logic [5:0] mem [1024];
  int n_wr = 0, n_rd = 0, n_fd = 0, n_rd_bad = 0, n_fd_bad = 0;
  logic [9:0] rd_addr, fd_addr;

  hub75_capture #(.COLS(64), .ROW_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .i_p_clk(p_clk), .i_p_lat(p_lat), .i_p_oe(p_oe), .i_p_addr(p_addr),
    .i_p_rgb1(p_rgb1), .i_p_rgb2(p_rgb2),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_row_done(row_done), .o_frame_done(frame_done),
    .o_overrun(overrun), .o_lat_drop(lat_drop),
    .o_oe_on_cycles(oe_on_cycles), .o_oe_stat_valid(oe_stat_valid)
  );

  always #5 clk = ~clk;

  // Capture-RAM model fed by the write port, sampled on the inactive edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      mem[wr_addr] = wr_data;
      n_wr++;
    end
    if (row_done === 1'b1) begin
      n_rd++;
      rd_addr = wr_addr;
      if (wr_en !== 1'b1) n_rd_bad++;
    end
    if (frame_done === 1'b1) begin
      n_fd++;
      fd_addr = wr_addr;
      if (row_done !== 1'b1) n_fd_bad++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_pix(input logic [5:0] v);
    p_rgb1 = v[2:0];
    p_rgb2 = v[5:3];
    p_clk  = 1'b0;
    cyc(2);
    p_clk  = 1'b1;
    cyc(2);
  endtask

  task automatic latch(input logic [3:0] row);
    p_addr = row;
    p_lat  = 1'b1;
    cyc(2);
    p_lat  = 1'b0;
    cyc(2);
  endtask

  task automatic wait_writes(input int target);
    for (int t = 0; t < 300 && n_wr < target; t++) cyc(1);
    cyc(10);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    cyc(4);
    rst = 1'b0;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    checks++; if (wr_addr !== 10'd0 || wr_data !== 6'd0) begin errors++; $display("FAIL reset_wr_bus got %h/%h want 0/0", wr_addr, wr_data); end
    checks++; if (overrun !== 1'b0 || lat_drop !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", overrun, lat_drop); end
    checks++; if (oe_on_cycles !== 16'd0 || oe_stat_valid !== 1'b0) begin errors++; $display("FAIL reset_oe got %0d/%b want 0/0", oe_on_cycles, oe_stat_valid); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (wr_en !== 1'b0 || row_done !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0 ||
          lat_drop !== 1'b0 || oe_stat_valid !== 1'b0 || wr_addr !== 10'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet got %0d active cycles want 0", bad); end
    checks++; if (n_wr != 0) begin errors++; $display("FAIL idle_writes got %0d want 0", n_wr); end
  endtask

  task automatic test_single_line();
    int base, rd0, fd0, errs;
    base = n_wr; rd0 = n_rd; fd0 = n_fd;
    for (int k = 0; k < 64; k++) shift_pix(6'(k));
    latch(4'd5);
    wait_writes(base + 64);
    errs = 0;
    for (int k = 0; k < 64; k++) if (mem[320 + k] !== 6'(k)) errs++;
    checks++; if (n_wr - base != 64) begin errors++; $display("FAIL line_count got %0d want 64", n_wr - base); end
    checks++; if (errs != 0) begin errors++; $display("FAIL line_data got %0d bad words want 0", errs); end
    checks++; if (n_rd - rd0 != 1 || rd_addr !== 10'h17F) begin errors++; $display("FAIL line_row_done got %0d at %h want 1 at 17f", n_rd - rd0, rd_addr); end
    checks++; if (n_fd - fd0 != 0) begin errors++; $display("FAIL line_frame_done got %0d want 0", n_fd - fd0); end
    checks++; if (n_rd_bad != 0) begin errors++; $display("FAIL row_done_alone got %0d want 0", n_rd_bad); end
  endtask

  task automatic test_frame();
    int base, rd0, fd0, errs;
    base = n_wr; rd0 = n_rd; fd0 = n_fd;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 64; k++) shift_pix(6'(r * 5 + k));
      latch(4'(r));
    end
    wait_writes(base + 1024);
    errs = 0;
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 64; k++) if (mem[r * 64 + k] !== 6'(r * 5 + k)) errs++;
    checks++; if (n_wr - base != 1024) begin errors++; $display("FAIL frame_count got %0d want 1024", n_wr - base); end
    checks++; if (errs != 0) begin errors++; $display("FAIL frame_data got %0d bad words want 0", errs); end
    checks++; if (n_rd - rd0 != 16) begin errors++; $display("FAIL frame_rows got %0d want 16", n_rd - rd0); end
    checks++; if (n_fd - fd0 != 1 || fd_addr !== 10'h3FF || n_fd_bad != 0) begin errors++; $display("FAIL frame_done got %0d at %h (%0d alone) want 1 at 3ff", n_fd - fd0, fd_addr, n_fd_bad); end
    checks++; if (overrun !== 1'b0 || lat_drop !== 1'b0) begin errors++; $display("FAIL frame_flags got %b%b want 00", overrun, lat_drop); end
  endtask

  task automatic test_overrun_and_drop();
    int base, rd0, errs;
    base = n_wr;
    for (int k = 0; k < 64; k++) shift_pix(6'(k + 1));
    shift_pix(6'd50);
    latch(4'd3);
    wait_writes(base + 64);
    errs = 0;
    for (int k = 1; k < 64; k++) if (mem[192 + k] !== 6'(k + 1)) errs++;
    checks++; if (overrun !== 1'b1 || lat_drop !== 1'b0) begin errors++; $display("FAIL overrun_flags got %b%b want 10", overrun, lat_drop); end
    checks++; if (mem[192] !== 6'd50) begin errors++; $display("FAIL overrun_col0 got %0d want 50", mem[192]); end
    checks++; if (errs != 0) begin errors++; $display("FAIL overrun_data got %0d bad words want 0", errs); end
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", overrun); end
    base = n_wr; rd0 = n_rd;
    for (int k = 0; k < 64; k++) shift_pix(6'(k) ^ 6'd21);
    latch(4'd7);
    cyc(6);
    latch(4'd8);
    wait_writes(base + 64);
    cyc(60);
    errs = 0;
    for (int k = 0; k < 64; k++) if (mem[448 + k] !== (6'(k) ^ 6'd21)) errs++;
    checks++; if (lat_drop !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL drop_flags got %b%b want 01", lat_drop, overrun); end
    checks++; if (n_wr - base != 64 || n_rd - rd0 != 1) begin errors++; $display("FAIL drop_count got %0d/%0d want 64/1", n_wr - base, n_rd - rd0); end
    checks++; if (errs != 0) begin errors++; $display("FAIL drop_data got %0d bad words want 0", errs); end
  endtask

  task automatic test_reset_mid_write();
    int base, errs;
    logic found;
    base = n_wr;
    found = 1'b0;
    for (int k = 0; k < 64; k++) shift_pix(6'(63 - k));
    latch(4'd9);
    for (int t = 0; t < 100 && !found; t++) begin
      if (wr_en === 1'b1 && wr_addr === 10'h254) found = 1'b1;
      else begin cyc(1); #1; end
    end
    rst = 1'b1;
    cyc(1);
    #1;
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach got %b want 1", found); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en got %b want 0", wr_en); end
    rst = 1'b0;
    cyc(20);
    checks++; if (n_wr - base != 21) begin errors++; $display("FAIL midrst_count got %0d want 21", n_wr - base); end
    base = n_wr;
    for (int k = 0; k < 64; k++) shift_pix(6'(k * 3));
    latch(4'd10);
    wait_writes(base + 64);
    errs = 0;
    for (int k = 0; k < 64; k++) if (mem[640 + k] !== 6'(k * 3)) errs++;
    checks++; if (n_wr - base != 64 || errs != 0) begin errors++; $display("FAIL midrst_next got %0d writes %0d bad want 64/0", n_wr - base, errs); end
  endtask

  task automatic test_oe_stats();
    logic [15:0] exp_on;
    logic        exp_valid, found, v_at, v_after;
    logic [15:0] on_at;
`ifdef HUB75_CAP_OE_STATS_EN
    exp_on = 16'd37; exp_valid = 1'b1;
`else
    exp_on = 16'd0;  exp_valid = 1'b0;
`endif
    latch(4'd11);
    cyc(80);
    p_oe = 1'b0;
    cyc(37);
    p_oe = 1'b1;
    cyc(10);
    p_addr = 4'd12;
    p_lat  = 1'b1;
    cyc(2);
    p_lat  = 1'b0;
    found = 1'b0; v_at = 1'b0; on_at = 16'd0;
    for (int t = 0; t < 20 && !found; t++) begin
      cyc(1);
      #1;
      if (wr_en === 1'b1) begin found = 1'b1; v_at = oe_stat_valid; on_at = oe_on_cycles; end
    end
    cyc(1);
    v_after = oe_stat_valid;
    checks++; if (!found) begin errors++; $display("FAIL oe_latch_seen got %b want 1", found); end
    checks++; if (v_at !== exp_valid || v_after !== 1'b0) begin errors++; $display("FAIL oe_valid got %b%b want %b0", v_at, v_after, exp_valid); end
    checks++; if (on_at !== exp_on) begin errors++; $display("FAIL oe_on_cycles got %0d want %0d", on_at, exp_on); end
    cyc(80);
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_frame();
    test_overrun_and_drop();
    test_reset_mid_write();
    test_oe_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
